// File: rtl/divisor_parametrico.sv
// rtl/divisor_parametrico.sv - multi-cycle restoring divider, signed/unsigned, TAMANYO-bit operands
module divisor_parametrico #(
  parameter int TAMANYO = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               START,
  input  logic               SIGNO,
  input  logic [TAMANYO-1:0] NUM,
  input  logic [TAMANYO-1:0] DEN,
  output logic [TAMANYO-1:0] COC,
  output logic [TAMANYO-1:0] RES,
  output logic               DONE,
  output logic               DIV0,
  output logic               BUSY
);

  localparam int W  = TAMANYO;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          signo_r;
  logic          neg_q;
  logic          neg_r;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  den_r;

  logic          num_neg;
  logic          den_neg;
  logic [W-1:0]  num_abs;
  logic [W-1:0]  den_abs;

  // Working remainder is one bit wider than the operands: after the shift it
  // can reach 2*den-1, which overflows W bits when den has its MSB set.
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  diff_lo;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  quo_nxt;

  // Operand magnitudes; in unsigned mode the raw values pass through untouched
  always_comb begin
    num_neg = SIGNO & NUM[W-1];
    den_neg = SIGNO & DEN[W-1];
    num_abs = num_neg ? (~NUM + 1'b1) : NUM;
    den_abs = den_neg ? (~DEN + 1'b1) : DEN;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When it fits the true difference is below den_r, so the low W bits are exact.
  always_comb begin
    shifted = {rem, quo[W-1]};
    fits    = (shifted >= {1'b0, den_r});
    diff_lo = shifted[W-1:0] - den_r;
    rem_nxt = fits ? diff_lo : shifted[W-1:0];
    quo_nxt = {quo[W-2:0], fits};
  end

  // Control FSM and all result registers; outputs change only on state transitions
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      cnt     <= '0;
      signo_r <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      den_r   <= '0;
      COC     <= '0;
      RES     <= '0;
      DONE    <= 1'b0;
      DIV0    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            BUSY <= 1'b1;
            if (DEN == '0) begin
              // Divide-by-zero short-circuits straight to completion
              COC   <= '1;
              RES   <= NUM;
              DIV0  <= 1'b1;
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              signo_r <= SIGNO;
              neg_q   <= num_neg ^ den_neg;
              neg_r   <= num_neg;
              quo     <= num_abs;
              den_r   <= den_abs;
              rem     <= '0;
              cnt     <= CW'(W - 1);
              state   <= CALC;
            end
          end
        end

        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == '0) begin
            state <= CORR;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        CORR: begin
          // Truncation toward zero: quotient sign from XOR, remainder follows dividend
          COC   <= (signo_r && neg_q) ? (~quo + 1'b1) : quo;
          RES   <= (signo_r && neg_r) ? (~rem + 1'b1) : rem;
          DIV0  <= 1'b0;
          DONE  <= 1'b1;
          state <= FIN;
        end

        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_parametrico.sv
// tb/tb_divisor_parametrico.sv - scoreboard bench for divisor_parametrico at 32 and 8 bits
module tb_divisor_parametrico;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;

  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] n32 = '0, d32 = '0;
  logic [31:0] c32, r32;
  logic        dn32, dz32, bz32;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0;
  logic [7:0]  c8, r8;
  logic        dn8, dz8, bz8;

  divisor_parametrico #(.TAMANYO(32)) u32 (
    .CLK(CLK), .RSTn(RSTn), .START(st32), .SIGNO(sg32), .NUM(n32), .DEN(d32),
    .COC(c32), .RES(r32), .DONE(dn32), .DIV0(dz32), .BUSY(bz32)
  );

  divisor_parametrico #(.TAMANYO(8)) u8 (
    .CLK(CLK), .RSTn(RSTn), .START(st8), .SIGNO(sg8), .NUM(n8), .DEN(d8),
    .COC(c8), .RES(r8), .DONE(dn8), .DIV0(dz8), .BUSY(bz8)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] coc;
    logic [63:0] res;
    logic        dz;
    int          at;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: pop expectation whenever DONE is seen
  always @(negedge CLK) begin
    if (dn32 === 1'b1) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL u32 unexpected DONE: got DONE=1 at cycle %0d expected no DONE", cyc);
      end else begin
        e32 = q32.pop_front();
        chk({e32.name, " COC"}, 64'(c32), e32.coc);
        chk({e32.name, " RES"}, 64'(r32), e32.res);
        chk({e32.name, " DIV0"}, 64'(dz32), 64'(e32.dz));
        chk({e32.name, " latency"}, 64'(cyc), 64'(e32.at));
      end
    end
  end

  always @(negedge CLK) begin
    if (dn8 === 1'b1) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL u8 unexpected DONE: got DONE=1 at cycle %0d expected no DONE", cyc);
      end else begin
        e8 = q8.pop_front();
        chk({e8.name, " COC"}, 64'(c8), e8.coc);
        chk({e8.name, " RES"}, 64'(r8), e8.res);
        chk({e8.name, " DIV0"}, 64'(dz8), 64'(e8.dz));
        chk({e8.name, " latency"}, 64'(cyc), 64'(e8.at));
      end
    end
  end

  // Launch one 32-bit operation; push the expected result when requested
  task automatic go32(input string nm, input logic s, input logic [31:0] n, input logic [31:0] d,
                      input logic [31:0] ec, input logic [31:0] er, input logic ez, input bit push);
    @(negedge CLK);
    st32 = 1'b1; sg32 = s; n32 = n; d32 = d;
    if (push) begin
      exp_t e;
      e.coc = 64'(ec); e.res = 64'(er); e.dz = ez; e.name = nm;
      e.at = cyc + ((d == 32'd0) ? 1 : 34);
      q32.push_back(e);
    end
    @(negedge CLK);
    st32 = 1'b0;
  endtask

  task automatic go8(input string nm, input logic s, input logic [7:0] n, input logic [7:0] d,
                     input logic [7:0] ec, input logic [7:0] er, input logic ez);
    exp_t e;
    @(negedge CLK);
    st8 = 1'b1; sg8 = s; n8 = n; d8 = d;
    e.coc = 64'(ec); e.res = 64'(er); e.dz = ez; e.name = nm;
    e.at = cyc + ((d == 8'd0) ? 1 : 10);
    q8.push_back(e);
    @(negedge CLK);
    st8 = 1'b0;
  endtask

  task automatic wait32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge CLK);
    if (q32.size() != 0) begin
      tests++; fails++;
      $display("FAIL u32 timeout: got %0d pending results expected 0", q32.size());
      q32.delete();
    end
    @(negedge CLK);
  endtask

  task automatic wait8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge CLK);
    if (q8.size() != 0) begin
      tests++; fails++;
      $display("FAIL u8 timeout: got %0d pending results expected 0", q8.size());
      q8.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset COC", 64'(c32), 64'd0);
    chk("reset RES", 64'(r32), 64'd0);
    chk("reset flags", 64'({dn32, dz32, bz32}), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Signed basics
    go32("4/2",   1'b1, 32'd4,          32'd2,          32'd2,          32'd0, 1'b0, 1); wait32();
    go32("4/-2",  1'b1, 32'd4,          32'hFFFF_FFFE,  32'hFFFF_FFFE,  32'd0, 1'b0, 1); wait32();
    go32("-4/2",  1'b1, 32'hFFFF_FFFC,  32'd2,          32'hFFFF_FFFE,  32'd0, 1'b0, 1); wait32();
    go32("-4/-2", 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFE,  32'd2,          32'd0, 1'b0, 1); wait32();
    go32("7/-2",  1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1, 1'b0, 1); wait32();
    go32("-7/2",  1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 1); wait32();
    // Unsigned with MSB set
    go32("u FFFFFFFF/2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1); wait32();
    go32("u 80000000/80000001", 1'b0, 32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0, 1); wait32();
    go32("u FFFFFFFF/FFFFFFFF", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1); wait32();
    // Divide by zero, then a valid division clears DIV0
    go32("9/0",   1'b0, 32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 1'b1, 1); wait32();
    go32("-5/0",  1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB, 1'b1, 1); wait32();
    go32("100/7", 1'b0, 32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 1); wait32();
    repeat (5) @(negedge CLK);
    chk("hold COC", 64'(c32), 64'd14);
    chk("hold RES", 64'(r32), 64'd2);
    // Overflow wrap
    go32("min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1); wait32();

    // START and operand changes during a running operation are ignored
    go32("ign 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1);
    repeat (8) @(negedge CLK);
    chk("busy mid-op", 64'(bz32), 64'd1);
    st32 = 1'b1; sg32 = 1'b1; n32 = 32'd5; d32 = 32'd1;
    @(negedge CLK);
    st32 = 1'b0; n32 = 32'd77; d32 = 32'd0;
    wait32();

    // Reset in the middle of an operation aborts it without DONE
    go32("abort", 1'b1, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0);
    repeat (13) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("abort COC", 64'(c32), 64'd0);
    chk("abort RES", 64'(r32), 64'd0);
    chk("abort flags", 64'({dn32, dz32, bz32}), 64'd0);
    repeat (3) @(negedge CLK);
    chk("abort still no DONE", 64'(dn32), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    go32("post-reset 4/2", 1'b1, 32'd4, 32'd2, 32'd2, 32'd0, 1'b0, 1); wait32();

    // 8-bit instance
    go8("w8 4/2",   1'b1, 8'd4,   8'd2,   8'd2,   8'd0, 1'b0); wait8();
    go8("w8 4/-2",  1'b1, 8'd4,   8'hFE,  8'hFE,  8'd0, 1'b0); wait8();
    go8("w8 -4/2",  1'b1, 8'hFC,  8'd2,   8'hFE,  8'd0, 1'b0); wait8();
    go8("w8 -4/-2", 1'b1, 8'hFC,  8'hFE,  8'd2,   8'd0, 1'b0); wait8();
    go8("w8 -128/-1", 1'b1, 8'h80, 8'hFF, 8'h80,  8'd0, 1'b0); wait8();
    go8("w8 u 255/16", 1'b0, 8'hFF, 8'd16, 8'h0F, 8'h0F, 1'b0); wait8();
    go8("w8 3/0",   1'b0, 8'd3,   8'd0,   8'hFF,  8'd3, 1'b1); wait8();

    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
